// File: rtl/mult_div_unit_if.sv
// mult_div_unit_if: operand/control bus and result bus of the E-stage
// multiply/divide unit.
//   start[2:0]       op code (001 multu, 010 mult, 011 divu, 100 div, else none)
//   A, B             forwarded rs / rt operands
//   MDaddress        1 = HI, 0 = LO (read and mthi/mtlo write)
//   MD_write_enable  mthi/mtlo strobe
//   busy             operation in flight
//   HI, LO           architectural registers
//   md_rdata         HI/LO read mux output
// master: pipeline side (drives ops), slave: the unit.
interface mult_div_unit_if;
  logic [2:0]  start;
  logic [31:0] A;
  logic [31:0] B;
  logic        MDaddress;
  logic        MD_write_enable;
  logic        busy;
  logic [31:0] HI;
  logic [31:0] LO;
  logic [31:0] md_rdata;

  modport master (
    output start, A, B, MDaddress, MD_write_enable,
    input  busy, HI, LO, md_rdata
  );

  modport slave (
    input  start, A, B, MDaddress, MD_write_enable,
    output busy, HI, LO, md_rdata
  );
endinterface

// File: rtl/mult_div_unit.sv
// mult_div_unit: multi-cycle multiply/divide unit holding HI/LO.
// The result is computed in full at the start edge and parked in shadow
// registers; the counter only models latency. HI/LO are committed on the
// edge where the counter reaches zero, so the new values appear in the
// same cycle busy drops.
// Ports:
//   clk    rising-edge clock
//   reset  asynchronous, active-low reset
//   md     mult_div_unit_if.slave (op/operands in, busy/HI/LO/md_rdata out)
module mult_div_unit #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic            clk,
  input  logic            reset,
  mult_div_unit_if.slave  md
);

  localparam logic [3:0] MULT_N = 4'(MULT_CYCLES);
  localparam logic [3:0] DIV_N  = 4'(DIV_CYCLES);

  typedef enum logic {IDLE, BUSY} state_e;

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] hi_q, hi_d, lo_q, lo_d;
  logic [31:0] hi_s_q, hi_s_d, lo_s_q, lo_s_d;
  logic        commit_q, commit_d;   // cleared for divide-by-zero

  // ---------------- arithmetic ----------------
  logic        op_mul, op_div, op_signed;
  logic [63:0] prod;
  logic [31:0] div_b, quot, rem;
  logic        div_ovf;

  always_comb begin
    op_mul    = (md.start == 3'b001) || (md.start == 3'b010);
    op_div    = (md.start == 3'b011) || (md.start == 3'b100);
    op_signed = (md.start == 3'b010) || (md.start == 3'b100);
    // low 64 bits of a 64x64 product equal the signed 32x32 product
    // when the operands are sign-extended
    if (op_signed)
      prod = {{32{md.A[31]}}, md.A} * {{32{md.B[31]}}, md.B};
    else
      prod = {32'b0, md.A} * {32'b0, md.B};
    // divisor forced nonzero so the divider never sees /0; the result
    // is discarded in that case anyway
    div_b   = (md.B == 32'b0) ? 32'd1 : md.B;
    div_ovf = op_signed && (md.A == 32'h8000_0000) && (md.B == 32'hFFFF_FFFF);
    if (div_ovf) begin
      quot = 32'h8000_0000;
      rem  = 32'b0;
    end else if (op_signed) begin
      quot = 32'($signed(md.A) / $signed(div_b));
      rem  = 32'($signed(md.A) % $signed(div_b));
    end else begin
      quot = md.A / div_b;
      rem  = md.A % div_b;
    end
  end

  // ---------------- next state ----------------
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    hi_s_d   = hi_s_q;
    lo_s_d   = lo_s_q;
    commit_d = commit_q;
    case (state_q)
      IDLE: begin
        if (op_mul) begin
          hi_s_d   = prod[63:32];
          lo_s_d   = prod[31:0];
          commit_d = 1'b1;
          cnt_d    = MULT_N;
          state_d  = BUSY;
        end else if (op_div) begin
          hi_s_d   = rem;
          lo_s_d   = quot;
          commit_d = (md.B != 32'b0);
          cnt_d    = DIV_N;
          state_d  = BUSY;
        end else if (md.MD_write_enable) begin
          if (md.MDaddress) hi_d = md.A;
          else              lo_d = md.A;
        end
      end
      BUSY: begin
        // new starts and mthi/mtlo are ignored here
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) begin
          state_d = IDLE;
          if (commit_q) begin
            hi_d = hi_s_q;
            lo_d = lo_s_q;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      cnt_q    <= 4'd0;
      hi_q     <= 32'b0;
      lo_q     <= 32'b0;
      hi_s_q   <= 32'b0;
      lo_s_q   <= 32'b0;
      commit_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      hi_s_q   <= hi_s_d;
      lo_s_q   <= lo_s_d;
      commit_q <= commit_d;
    end
  end

  assign md.busy     = (state_q == BUSY);
  assign md.HI       = hi_q;
  assign md.LO       = lo_q;
  assign md.md_rdata = md.MDaddress ? hi_q : lo_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// Scoreboard bench for mult_div_unit: each issued op pushes its expected
// HI/LO and busy length; a monitor pops on every busy falling edge.
module tb_mult_div_unit;
  localparam int MC = 5;
  localparam int DC = 10;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  mult_div_unit_if md();

  mult_div_unit #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
    .clk   (clk),
    .reset (rst_n),
    .md    (md.slave)
  );

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    int          n;
  } exp_t;

  exp_t        sb_q[$];
  int          checks = 0;
  int          fails  = 0;
  logic [31:0] m_hi = 32'b0;
  logic [31:0] m_lo = 32'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: plain 64-bit integer arithmetic on the architectural rules.
  function automatic void model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                                inout logic [31:0] hi, inout logic [31:0] lo);
    longint          sa, sb, sp;
    longint unsigned ua, ub, up;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = longint'(a);
    ub = longint'(b);
    case (op)
      3'b001: begin up = ua * ub; hi = up[63:32]; lo = up[31:0]; end
      3'b010: begin sp = sa * sb; hi = sp[63:32]; lo = sp[31:0]; end
      3'b011: if (b != 0) begin up = ua / ub; lo = up[31:0]; up = ua % ub; hi = up[31:0]; end
      3'b100: if (b != 0) begin sp = sa / sb; lo = sp[31:0]; sp = sa % sb; hi = sp[31:0]; end
      default: ;
    endcase
  endfunction

  // ---------------- monitor ----------------
  initial begin
    int   bcnt;
    logic prev_busy;
    exp_t e;
    bcnt = 0;
    prev_busy = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        bcnt = 0;
        prev_busy = 1'b0;
      end else begin
        if (md.busy) bcnt++;
        else if (prev_busy) begin
          if (sb_q.size() == 0) begin
            chk("unexpected_completion", 32'd1, 32'd0);
          end else begin
            e = sb_q.pop_front();
            chk("result_HI", md.HI, e.hi);
            chk("result_LO", md.LO, e.lo);
            chk("busy_cycles", 32'(bcnt), 32'(e.n));
            chk("md_rdata", md.md_rdata, md.MDaddress ? e.hi : e.lo);
          end
          bcnt = 0;
        end
        prev_busy = md.busy;
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    exp_t        e;
    logic [31:0] h, l;
    h = m_hi;
    l = m_lo;
    @(negedge clk);
    md.start = op; md.A = a; md.B = b;
    model(op, a, b, h, l);
    e.hi = h; e.lo = l;
    e.n  = (op == 3'b001 || op == 3'b010) ? MC : DC;
    sb_q.push_back(e);
    m_hi = h; m_lo = l;
    @(negedge clk);
    md.start = 3'b000;
    chk("busy_rise", {31'b0, md.busy}, 32'd1);
  endtask

  task automatic wait_idle();
    int k;
    k = 0;
    while (md.busy === 1'b1 && k < 40) begin
      @(negedge clk);
      k++;
    end
    chk("idle_timeout", {31'b0, md.busy}, 32'd0);
  endtask

  task automatic mt(input logic hi_sel, input logic [31:0] v);
    @(negedge clk);
    md.MD_write_enable = 1'b1; md.MDaddress = hi_sel; md.A = v;
    @(negedge clk);
    md.MD_write_enable = 1'b0;
    if (hi_sel) m_hi = v; else m_lo = v;
    chk("mt_HI", md.HI, m_hi);
    chk("mt_LO", md.LO, m_lo);
    chk("mt_rdata", md.md_rdata, hi_sel ? m_hi : m_lo);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [2:0]  op;
    logic [31:0] a, b;
    rst_n = 1'b0;
    md.start = 3'b000; md.A = 32'b0; md.B = 32'b0;
    md.MDaddress = 1'b0; md.MD_write_enable = 1'b0;
    @(negedge clk);
    chk("rst_HI", md.HI, 32'b0);
    chk("rst_LO", md.LO, 32'b0);
    chk("rst_busy", {31'b0, md.busy}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // directed arithmetic
    issue(3'b010, 32'hFFFF_FFFD, 32'd7);        wait_idle();
    chk("mult_HI", md.HI, 32'hFFFF_FFFF);
    chk("mult_LO", md.LO, 32'hFFFF_FFEB);
    issue(3'b001, 32'hFFFF_FFFF, 32'd2);        wait_idle();
    chk("multu_HI", md.HI, 32'h0000_0001);
    chk("multu_LO", md.LO, 32'hFFFF_FFFE);
    issue(3'b100, 32'hFFFF_FFF9, 32'd2);        wait_idle();
    chk("div_HI", md.HI, 32'hFFFF_FFFF);
    chk("div_LO", md.LO, 32'hFFFF_FFFD);
    issue(3'b011, 32'hFFFF_FFF9, 32'd2);        wait_idle();
    chk("divu_HI", md.HI, 32'h0000_0001);
    chk("divu_LO", md.LO, 32'h7FFF_FFFC);
    issue(3'b100, 32'h8000_0000, 32'hFFFF_FFFF); wait_idle();
    chk("div_ovf_HI", md.HI, 32'h0);
    chk("div_ovf_LO", md.LO, 32'h8000_0000);

    // divide by zero keeps preloaded HI/LO
    mt(1'b1, 32'h11);
    mt(1'b0, 32'h22);
    issue(3'b100, 32'h1234, 32'd0);             wait_idle();
    chk("dz_HI", md.HI, 32'h11);
    chk("dz_LO", md.LO, 32'h22);

    // reserved opcode does nothing
    @(negedge clk);
    md.start = 3'b110; md.A = 32'd5; md.B = 32'd6;
    @(negedge clk);
    md.start = 3'b000;
    chk("reserved_busy", {31'b0, md.busy}, 32'd0);
    chk("reserved_HI", md.HI, 32'h11);

    // mthi and a new start while busy are ignored
    issue(3'b100, 32'd100, 32'd7);
    @(negedge clk);
    md.MD_write_enable = 1'b1; md.MDaddress = 1'b1; md.A = 32'hDEAD;
    @(negedge clk);
    md.MD_write_enable = 1'b0;
    chk("busy_mthi_ignored", md.HI, 32'h11);
    md.start = 3'b001; md.A = 32'd3; md.B = 32'd3;
    @(negedge clk);
    md.start = 3'b000;
    wait_idle();
    mt(1'b0, 32'hBEEF);

    // reset mid-operation aborts without commit
    issue(3'b010, 32'd9, 32'd9);                // now between edges t0+1 and t0+2
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    sb_q.delete();
    m_hi = 32'b0; m_lo = 32'b0;
    #1;
    chk("abort_HI", md.HI, 32'b0);
    chk("abort_LO", md.LO, 32'b0);
    chk("abort_busy", {31'b0, md.busy}, 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (8) @(negedge clk);
    chk("no_stale_HI", md.HI, 32'b0);
    chk("no_stale_LO", md.LO, 32'b0);

    // randomized ops interleaved with mthi/mtlo
    for (int i = 0; i < 60; i++) begin
      op = 3'($urandom_range(1, 4));
      a  = ($urandom_range(0, 5) == 0) ? 32'($urandom_range(0, 20)) : 32'($urandom);
      case ($urandom_range(0, 7))
        0:       b = 32'b0;
        1, 2:    b = 32'($urandom_range(1, 9));
        3:       b = 32'hFFFF_FFFF;
        default: b = 32'($urandom);
      endcase
      if ($urandom_range(0, 4) == 0) mt(1'($urandom), 32'($urandom));
      md.MDaddress = 1'($urandom);
      issue(op, a, b);
      wait_idle();
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    repeat (3) @(negedge clk);
    chk("scoreboard_empty", 32'(sb_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end
endmodule
